// File: rtl/turn_scheduler.sv
// turn_scheduler: turn sequencer for the two-player artillery game.
// Sits between the keyboard decoder and the two player instances. It hands the
// keyboard to one player at a time, times the aiming turn, waits for that
// player's bomb to detonate, lets the blast settle and then either passes the
// turn to the other player or declares the game result.
// Optional build macro: TURN_PAUSE_EN adds a pause toggle on PAUSE_KEY.
module turn_scheduler #(
    parameter int unsigned TURN_FRAMES   = 600,
    parameter int unsigned FLIGHT_FRAMES = 300,
    parameter int unsigned SETTLE_FRAMES = 30,
    parameter logic [7:0]  KEY_IDLE      = 8'h00,
    parameter logic [7:0]  START_KEY     = 8'h28
`ifdef TURN_PAUSE_EN
    ,
    parameter logic [7:0]  PAUSE_KEY     = 8'h13
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    input  logic [7:0] shoot0,
    input  logic [7:0] shoot1,
    input  logic       boomed0,
    input  logic       boomed1,
    input  logic [9:0] hp0,
    input  logic [9:0] hp1,
    output logic [7:0] key_p0,
    output logic [7:0] key_p1,
    output logic       active_id,
    output logic [9:0] turn_time,
    output logic [2:0] state,
    output logic       winner_valid,
    output logic       winner_id,
    output logic       draw,
    output logic       paused
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AIM    = 3'd1,
        S_FLIGHT = 3'd2,
        S_SETTLE = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    // Counter reload and terminal values, all in the 10-bit counter domain.
    localparam logic [9:0] TURN_INIT   = 10'(TURN_FRAMES);
    localparam logic [9:0] FLIGHT_LAST = 10'(FLIGHT_FRAMES - 1);
    localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_FRAMES - 1);
    localparam logic [9:0] CNT_MAX     = 10'h3FF;

    state_t     cur_state;
    state_t     nxt_state;

    logic [9:0] flight_cnt;
    logic [9:0] settle_cnt;
    logic       shoot_held;
    logic       boom0_q;
    logic       boom1_q;

    logic       active_nxt;
    logic [9:0] turn_nxt;
    logic [9:0] flight_nxt;
    logic [9:0] settle_nxt;
    logic       held_nxt;
    logic       wv_nxt;
    logic       wid_nxt;
    logic       draw_nxt;
    logic [7:0] key0_nxt;
    logic [7:0] key1_nxt;

    logic       hold;
    logic       shoot_now;
    logic       aim_release;
    logic       aim_expire;
    logic       boom_rise;
    logic       dead0;
    logic       dead1;
    logic       key_pass;

    assign state = cur_state;

    // Shoot key of whichever player owns the turn, compared against the live keycode.
    assign shoot_now   = (keycode == (active_id ? shoot1 : shoot0));
    // Release of a held shoot key launches the bomb.
    assign aim_release = shoot_held & ~shoot_now;
    assign aim_expire  = frame_tick & (turn_time == 10'd1);
    // Only the active player's detonation ends the flight.
    assign boom_rise   = active_id ? (boomed1 & ~boom1_q) : (boomed0 & ~boom0_q);
    // Negative health shows up as bit 9 set; treat it like zero.
    assign dead0       = (hp0 == 10'd0) | hp0[9];
    assign dead1       = (hp1 == 10'd0) | hp1[9];

`ifdef TURN_PAUSE_EN
    logic pause_q;
    logic pause_now;
    logic pause_rise;
    logic pause_ok;
    logic paused_nxt;

    assign pause_now  = (keycode == PAUSE_KEY);
    assign pause_rise = pause_now & ~pause_q;
    assign pause_ok   = (cur_state == S_AIM) | (cur_state == S_FLIGHT) | (cur_state == S_SETTLE);
    assign paused_nxt = paused ^ (pause_rise & pause_ok);
    // Freeze on the toggling clock too, so neither edge of a pause lets a counter slip.
    assign hold       = paused | paused_nxt;

    // Pause key edge register and the pause flag, dropped whenever play stops.
    always_ff @(posedge clk) begin
        if (reset) begin
            pause_q <= 1'b0;
            paused  <= 1'b0;
        end else begin
            pause_q <= pause_now;
            if ((nxt_state == S_IDLE) || (nxt_state == S_OVER)) begin
                paused <= 1'b0;
            end else begin
                paused <= paused_nxt;
            end
        end
    end
`else
    assign hold   = 1'b0;
    assign paused = 1'b0;
`endif

    // Keys reach the active player only while the turn stays in live aiming, so
    // an expiry drops the key in the same clock and the player launches at once.
    assign key_pass = (cur_state == S_AIM) & (nxt_state == S_AIM) & ~hold;
    assign key0_nxt = (key_pass & ~active_id) ? keycode : KEY_IDLE;
    assign key1_nxt = (key_pass &  active_id) ? keycode : KEY_IDLE;

    // Next-state, counter and result logic for the turn sequence.
    always_comb begin
        nxt_state  = cur_state;
        active_nxt = active_id;
        turn_nxt   = turn_time;
        flight_nxt = flight_cnt;
        settle_nxt = settle_cnt;
        held_nxt   = shoot_held;
        wv_nxt     = winner_valid;
        wid_nxt    = winner_id;
        draw_nxt   = draw;
        if (!hold) begin
            held_nxt = 1'b0;
            case (cur_state)
                S_IDLE, S_OVER: begin
                    if (keycode == START_KEY) begin
                        nxt_state  = S_AIM;
                        active_nxt = 1'b0;
                        turn_nxt   = TURN_INIT;
                        wv_nxt     = 1'b0;
                        wid_nxt    = 1'b0;
                        draw_nxt   = 1'b0;
                    end
                end
                S_AIM: begin
                    held_nxt = shoot_now;
                    if (frame_tick && (turn_time != 10'd0)) begin
                        turn_nxt = turn_time - 10'd1;
                    end
                    if (aim_release || (aim_expire && shoot_held)) begin
                        nxt_state  = S_FLIGHT;
                        flight_nxt = 10'd0;
                    end else if (aim_expire) begin
                        nxt_state  = S_SETTLE;
                        settle_nxt = 10'd0;
                    end
                end
                S_FLIGHT: begin
                    if (frame_tick && (flight_cnt != CNT_MAX)) begin
                        flight_nxt = flight_cnt + 10'd1;
                    end
                    if (boom_rise || (frame_tick && (flight_cnt >= FLIGHT_LAST))) begin
                        nxt_state  = S_SETTLE;
                        settle_nxt = 10'd0;
                    end
                end
                S_SETTLE: begin
                    if (frame_tick && (settle_cnt != CNT_MAX)) begin
                        settle_nxt = settle_cnt + 10'd1;
                    end
                    if (frame_tick && (settle_cnt >= SETTLE_LAST)) begin
                        if (dead0 && dead1) begin
                            nxt_state = S_OVER;
                            draw_nxt  = 1'b1;
                        end else if (dead0 || dead1) begin
                            nxt_state = S_OVER;
                            wv_nxt    = 1'b1;
                            wid_nxt   = dead0;
                        end else begin
                            nxt_state  = S_AIM;
                            active_nxt = ~active_id;
                            turn_nxt   = TURN_INIT;
                        end
                    end
                end
                default: begin
                    nxt_state = S_IDLE;
                end
            endcase
        end
    end

    // State register, counters, edge detectors and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state    <= S_IDLE;
            active_id    <= 1'b0;
            turn_time    <= 10'd0;
            flight_cnt   <= 10'd0;
            settle_cnt   <= 10'd0;
            shoot_held   <= 1'b0;
            boom0_q      <= 1'b0;
            boom1_q      <= 1'b0;
            winner_valid <= 1'b0;
            winner_id    <= 1'b0;
            draw         <= 1'b0;
            key_p0       <= KEY_IDLE;
            key_p1       <= KEY_IDLE;
        end else begin
            cur_state    <= nxt_state;
            active_id    <= active_nxt;
            turn_time    <= turn_nxt;
            flight_cnt   <= flight_nxt;
            settle_cnt   <= settle_nxt;
            shoot_held   <= held_nxt;
            boom0_q      <= boomed0;
            boom1_q      <= boomed1;
            winner_valid <= wv_nxt;
            winner_id    <= wid_nxt;
            draw         <= draw_nxt;
            key_p0       <= key0_nxt;
            key_p1       <= key1_nxt;
        end
    end

endmodule
